// File: rtl/rv32_mem_pkg.sv
// Shared constants for the RV32I data-memory write path.
//   - byte-enable patterns for byte, halfword and word stores
//   - store funct3 encodings (SB/SH/SW)
//   - drain FSM state encoding used by the store write buffer
package rv32_mem_pkg;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic {
    DRAIN_RUN   = 1'b0,
    DRAIN_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane formatter.
// Ports:
//   addr_allign - byte-lane offset from the store unit
//   B, H        - byte / halfword store flags (B wins when both are set)
//   st_data     - rs2 value, store data in the LSBs
//   be          - byte enables for the 32-bit memory word
//   wdata       - store data replicated across every lane it may land in
module store_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  addr_allign,
  input  logic        B,
  input  logic        H,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  always_comb begin
    be    = BE_W;
    wdata = st_data;
    if (B) begin
      be    = BE_B0 << addr_allign;
      wdata = {4{st_data[7:0]}};
    end else if (H) begin
      // Only the upper offset bit matters; misaligned halfwords are the
      // store unit's problem, not ours.
      be    = addr_allign[1] ? BE_H_HI : BE_H_LO;
      wdata = {2{st_data[15:0]}};
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: formats stores into byte lanes, queues them in a
// DEPTH-entry FIFO and drains them to data memory over req/ack.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   st_valid/st_ready         - store handshake from execute/memory stage
//   st_addr, st_data          - store byte address and rs2 data
//   addr_allign, B, H         - lane offset and size from the store unit
//   mem_req/mem_ack           - head entry write request / acceptance
//   mem_addr, mem_wdata, mem_be - head entry (word address, data, enables)
//   ld_addr, ld_hazard        - load address and pending-store match flag
//   drain, empty              - fence request and buffer-empty status
module store_write_buffer
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic [1:0]    addr_allign,
  input  logic          B,
  input  logic          H,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  input  logic          drain,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WA = AW - 2;

  logic [WA-1:0] addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    be_mem   [DEPTH];

  logic [DEPTH-1:0] valid_reg;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  drain_state_e     state_reg, state_next;

  logic [3:0]       fmt_be;
  logic [31:0]      fmt_wdata;
  logic             full, drain_lock, enq, deq;
  logic [DEPTH-1:0] hit;
  logic             unused_addr_bits;

  // Byte offsets come from addr_allign, never from the raw address.
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  store_lane_align u_align (
    .addr_allign (addr_allign),
    .B           (B),
    .H           (H),
    .st_data     (st_data),
    .be          (fmt_be),
    .wdata       (fmt_wdata)
  );

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign drain_lock = (state_reg == DRAIN_DRAIN);
  // No pass-through: a full buffer refuses even if the head leaves now.
  assign st_ready   = !full && !drain_lock;
  assign enq        = st_valid && st_ready;
  assign mem_req    = !empty;
  assign deq        = mem_req && mem_ack;

  // Head outputs are forced to zero while empty so stale storage never
  // shows on the memory bus.
  assign mem_addr  = empty ? '0 : {addr_mem[rd_ptr_reg], 2'b00};
  assign mem_wdata = empty ? '0 : data_mem[rd_ptr_reg];
  assign mem_be    = empty ? '0 : be_mem[rd_ptr_reg];

  // Storage needs no reset: valid_reg and count_reg gate every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_reg] <= st_addr[AW-1:2];
      data_mem[wr_ptr_reg] <= fmt_wdata;
      be_mem[wr_ptr_reg]   <= fmt_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= DRAIN_RUN;
    end else begin
      state_reg <= state_next;
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Per-entry valid bits and hazard comparators. An entry can never be
  // written and retired in the same cycle: wr==rd only when empty (no
  // dequeue) or full (no enqueue).
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (enq && (wr_ptr_reg == PW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (deq && (rd_ptr_reg == PW'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
      assign hit[gi] = valid_reg[gi] && (addr_mem[gi] == ld_addr[AW-1:2]);
    end
  endgenerate

  assign ld_hazard = |hit;

  // Drain FSM: once entered, runs to completion even if drain drops.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DRAIN_RUN: begin
        if (drain && !empty) state_next = DRAIN_DRAIN;
      end
      DRAIN_DRAIN: begin
        if (empty || (deq && count_reg == CW'(1))) state_next = DRAIN_RUN;
      end
      default: state_next = DRAIN_RUN;
    endcase
  end

endmodule
